serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 147 ++++++++++++++
 tb/tb_serial_add_sub.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Digit-serial adder/subtractor. Processes DIGIT bits per clock
//            from the LSB upward through a DIGIT-wide ripple of full-adder
//            cells with a registered carry between digits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   operation request, sampled only when not busy
//   sub    in   0 = A + B, 1 = A - B (sampled with start)
//   A, B   in   WIDTH-bit operands (sampled with start)
//   busy   out  operation in progress (RUN and DONE states)
//   done   out  one-cycle completion pulse
//   S      out  registered sum/difference
//   C_out  out  carry out of MSB (subtract: 1 = no borrow)
//   V      out  two's-complement overflow
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             load, step;
  logic [WIDTH-1:0] a_reg, b_reg, psum, psum_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last_digit;

  logic [DIGIT-1:0] dsum;
  logic             ripple_c, c_msb, d_cout;

  // Ripple of DIGIT full-adder cells over the low digit of the operands.
  // c_msb holds the carry entering the top cell of the digit; on the last
  // digit that is the carry into the word MSB, needed for overflow.
  always_comb begin
    ripple_c = carry;
    c_msb    = carry;
    dsum     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = ripple_c;
      dsum[i]  = a_reg[i] ^ b_reg[i] ^ ripple_c;
      ripple_c = (a_reg[i] & b_reg[i]) | (ripple_c & (a_reg[i] ^ b_reg[i]));
    end
    d_cout = ripple_c;
  end

  // New digit enters at the MSB end so that after N steps the first digit
  // has arrived at bit 0.
  assign psum_next  = (psum >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last_digit = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        // Back-to-back: a start here reloads and skips IDLE.
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      psum  <= '0;
      carry <= 1'b0;
      count <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
    end else if (load) begin
      // Subtract as A + ~B + 1, the +1 injected as the initial carry.
      a_reg <= A;
      b_reg <= B ^ {WIDTH{sub}};
      carry <= sub;
      count <= LAST_COUNT;
      psum  <= '0;
    end else if (step) begin
      a_reg <= a_reg >> DIGIT;
      b_reg <= b_reg >> DIGIT;
      carry <= d_cout;
      psum  <= psum_next;
      if (!last_digit) begin
        count <= count - CW'(1);
      end else begin
        S     <= psum_next;
        C_out <= d_cout;
        V     <= c_msb ^ d_cout;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Scoreboard bench for serial_add_sub, three configurations
//            (WIDTH=8 with DIGIT=1, 2, 8) sharing one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [9:0]   exp_r = '0;   // {C_out, V, S} expected for the current stimulus

  int compared   = 0;
  int mismatched = 0;

  logic         busy_w [3];
  logic         done_w [3];
  logic         c_w    [3];
  logic         v_w    [3];
  logic [W-1:0] s_w    [3];

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int         ai = int'(a);
    int         bi = int'(b);
    int         r;
    logic       c, v;
    logic [7:0] r8;
    if (!s) begin
      r = ai + bi;
      c = (r > 255);
    end else begin
      r = ai - bi;
      c = (ai >= bi);
    end
    r8 = 8'(r & 255);
    if (!s) v = (a[7] == b[7]) && (r8[7] != a[7]);
    else    v = (a[7] != b[7]) && (r8[7] != a[7]);
    return {c, v, r8};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    localparam int N = W / D;

    logic [9:0] q[$];
    logic [9:0] last_r = '0;
    logic [9:0] popped;
    int         left     = 0;   // cycles until the DUT is idle again
    int         accepted = 0;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .A     (A),
      .B     (B),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .S     (s_w[g]),
      .C_out (c_w[g]),
      .V     (v_w[g])
    );

    // Acceptance model: a request is taken when idle or in the done cycle;
    // it then occupies N compute cycles plus one done cycle.
    always @(posedge clock or posedge reset) begin
      if (reset) begin
        left = 0;
        q.delete();
      end else if (left <= 1 && start) begin
        q.push_back(exp_r);
        left = N + 1;
        accepted++;
      end else if (left > 0) begin
        left--;
      end
    end

    always @(negedge clock) begin
      if (reset) begin
        last_r = '0;
      end else begin
        check($sformatf("busy[D=%0d]", D), 32'(busy_w[g]), 32'(left > 0));
        check($sformatf("done[D=%0d]", D), 32'(done_w[g]), 32'(left == 1));
        if (left == 1) begin
          popped = (q.size() > 0) ? q.pop_front() : 10'h3FF;
          last_r = popped;
        end
        check($sformatf("result{C,V,S}[D=%0d]", D), 32'({c_w[g], v_w[g], s_w[g]}), 32'(last_r));
      end
    end
  end

  function automatic logic all_idle();
    return (g_cfg[0].left == 0) && (g_cfg[1].left == 0) && (g_cfg[2].left == 0);
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [9:0] e);
    @(negedge clock);
    A     = a;
    B     = b;
    sub   = s;
    exp_r = e;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!all_idle() && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(all_idle()), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_outputs[%0d]", tag, i),
            32'({busy_w[i], done_w[i], c_w[i], v_w[i], s_w[i]}), 32'd0);
  endtask

  // Directed vectors with hand-derived {C_out, V, S}.
  logic [7:0] ta [6] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h33};
  logic [7:0] tb [6] = '{8'h33, 8'h01, 8'h01, 8'h20, 8'h01, 8'h33};
  logic       ts [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
  logic [9:0] te [6] = '{{2'b01, 8'h8D}, {2'b10, 8'h00}, {2'b01, 8'h80},
                         {2'b00, 8'hF0}, {2'b11, 8'h7F}, {2'b10, 8'h00}};

  initial begin
    int base;
    int n;

    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_zero_outputs("reset");
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], ts[i], te[i]);
      wait_idle();
    end

    // start during RUN with other operands: ignored by the DIGIT=1 unit.
    issue(8'h21, 8'h14, 1'b0, {2'b00, 8'h35});
    repeat (2) @(negedge clock);
    A = 8'h70; B = 8'h70; sub = 1'b0; exp_r = ref_op(8'h70, 8'h70, 1'b0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // start held through DONE: second operation accepted back-to-back.
    @(negedge clock);
    A = 8'h11; B = 8'h22; sub = 1'b0; exp_r = {2'b00, 8'h33};
    start = 1'b1;
    @(negedge clock);
    A = 8'h40; B = 8'h05; sub = 1'b1; exp_r = {2'b10, 8'h3B};
    repeat (9) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    issue(8'h5A, 8'h33, 1'b0, {2'b01, 8'h8D});
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_reset");
    @(negedge clock);
    #1 reset = 1'b0;
    issue(8'h01, 8'h02, 1'b0, {2'b00, 8'h03});
    wait_idle();

    // Randomised sweep: at least 1000 operations on the slowest unit
    // (the faster ones accept more from the same stream).
    base = g_cfg[0].accepted;
    n    = 0;
    while ((g_cfg[0].accepted - base) < 1000 && n < 30000) begin
      @(negedge clock);
      A     = 8'($urandom);
      B     = 8'($urandom);
      sub   = 1'($urandom);
      exp_r = ref_op(A, B, sub);
      start = ($urandom_range(0, 3) != 0);
      n++;
    end
    @(negedge clock);
    start = 1'b0;
    check("random_op_budget", 32'((g_cfg[0].accepted - base) >= 1000), 32'd1);
    wait_idle();
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
